mips_dmem_responder: RTL and testbench
======================================

MIPS_DMEM_RESPONDER -- requirements
Module: mips_dmem_responder

Interface
REQ-001 SHALL have parameter DATA_START, default 32'h10000000, byte address of the first word served.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two, 16..65536).
REQ-003 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response (legal range 1..15).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port mem_req_valid  input  1  core presents a data request this cycle.
REQ-007 SHALL have port mem_addr  input  30  word address (byte address [31:2]).
REQ-008 SHALL have port mem_data_in  input  32  store data from the core.
REQ-009 SHALL have port mem_write_en  input  4  byte write mask; bit i enables byte [8i+7:8i]; 4'b0000 = load.
REQ-010 SHALL have port mem_busy  output  1  request in flight; core stalls while high.
REQ-011 SHALL have port mem_resp_valid  output  1  single-cycle pulse marking response.
REQ-012 SHALL have port mem_data_out  output  32  load data, registered.
REQ-013 SHALL have port mem_excpt  output  1  address out of range, qualified by mem_resp_valid.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; mem_busy = (state != IDLE).
REQ-015 SHALL accept a request only in IDLE with mem_req_valid=1, latching mem_addr, mem_data_in, mem_write_en at that edge; mem_req_valid in WAIT/RESP SHALL be ignored.
REQ-016 SHALL on acceptance go to RESP if LATENCY=1, else to WAIT with a down-counter loaded with LATENCY-2.
REQ-017 SHALL in WAIT decrement the counter each edge and go to RESP on the edge where the counter is 0.
REQ-018 SHALL assert mem_resp_valid for exactly the RESP cycle, i.e. the cycle after the LATENCY-th edge following acceptance, then return to IDLE.
REQ-019 SHALL treat a request as in range iff DATA_START[31:2] <= latched addr < DATA_START[31:2]+DEPTH_WORDS, using 30-bit unsigned compare without wrap-around.
REQ-020 SHALL index the array with (latched addr - DATA_START[31:2]), truncated to log2(DEPTH_WORDS) bits.
REQ-021 SHALL for an in-range store write only the enabled bytes, committed on the edge entering RESP; disabled bytes unchanged.
REQ-022 SHALL for an in-range load load mem_data_out with the addressed word on the edge entering RESP.
REQ-023 SHALL for an in-range store load mem_data_out with 32'h0.
REQ-024 SHALL for an out-of-range request suppress any write, load mem_data_out with 32'h0, and set mem_excpt=1 in the RESP cycle.
REQ-025 SHALL drive mem_excpt=0 whenever mem_resp_valid=0.
REQ-026 SHALL hold mem_data_out from RESP until the next response or reset.
REQ-027 SHALL sustain at most one request per LATENCY+1 cycles; a request held high through RESP is accepted again in the following IDLE cycle.
REQ-028 SHALL not initialise or clear the storage array; initial contents are undefined (benches preload by hierarchical access).

Reset
REQ-029 SHALL on rst=1 immediately force state IDLE, counter 0, mem_busy=0, mem_resp_valid=0, mem_excpt=0, mem_data_out=32'h0.
REQ-030 SHALL on reset during WAIT abort the request; a pending store SHALL NOT be committed and no response SHALL be produced.
REQ-031 SHALL accept a request on the first rising edge with rst low and mem_req_valid high.

Verification
REQ-032 Store 32'hDEADBEEF, mask 4'b1111, addr 30'h04000000 (byte 0x10000000), LATENCY=2 -> busy 2 cycles, resp_valid in 2nd busy cycle, excpt=0, data_out=0; later load same addr -> data_out=32'hDEADBEEF.
REQ-033 Preload word 32'h11223344 at addr 30'h04000001, store 32'hAABBCCDD mask 4'b0101 -> subsequent load returns 32'h11BB33DD.
REQ-034 Load addr 30'h03FFFFFF and addr 30'h04000400 (DEPTH_WORDS=1024) -> resp_valid with excpt=1, data_out=0, array unchanged; addr 30'h040003FF -> excpt=0.
REQ-035 LATENCY=1 and LATENCY=15 builds, mem_req_valid held high continuously -> resp_valid pulses every 2 and 16 cycles respectively, never two in consecutive cycles.
REQ-036 Store 32'h12345678 accepted, rst pulsed high one cycle into WAIT (LATENCY=4) -> all outputs 0 asynchronously, no resp_valid, later load of that addr returns pre-store value.

Source files
------------

// File: rtl/mips_dmem_responder.sv
// Fixed-latency data memory responder for a MIPS core: one request at a
// time, byte-masked stores, range-checked loads with an exception flag.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   mem_req_valid   request strobe (sampled only while idle)
//   mem_addr        30-bit word address (byte address [31:2])
//   mem_data_in     store data
//   mem_write_en    byte write mask, 4'b0000 = load
//   mem_busy        high while a request is in flight
//   mem_resp_valid  one-cycle response pulse
//   mem_data_out    registered load data, held until next response
//   mem_excpt       out-of-range flag, valid with mem_resp_valid
module mips_dmem_responder #(
    parameter logic [31:0] DATA_START  = 32'h10000000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_valid,
    input  logic [29:0] mem_addr,
    input  logic [31:0] mem_data_in,
    input  logic [3:0]  mem_write_en,
    output logic        mem_busy,
    output logic        mem_resp_valid,
    output logic [31:0] mem_data_out,
    output logic        mem_excpt
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [29:0] BASE     = DATA_START[31:2];
    // One extra bit so the upper bound never wraps around.
    localparam logic [30:0] LIMIT    = {1'b0, BASE} + 31'(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [29:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  mask_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [29:0]   sel_addr;
    logic [31:0]   sel_data;
    logic [3:0]    sel_mask;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          commit;

    // With LATENCY=1 the acceptance edge is also the commit edge, so the
    // live inputs are used instead of the (not yet loaded) latches.
    always_comb begin
        sel_addr = addr_q;
        sel_data = data_q;
        sel_mask = mask_q;
        if (state == IDLE) begin
            sel_addr = mem_addr;
            sel_data = mem_data_in;
            sel_mask = mem_write_en;
        end
    end

    assign in_range = ({1'b0, sel_addr} >= {1'b0, BASE}) &&
                      ({1'b0, sel_addr} < LIMIT);
    assign idx      = AW'(sel_addr - BASE);

    assign commit = ((state == IDLE) && mem_req_valid && (LATENCY == 1)) ||
                    ((state == WAIT) && (cnt == 4'd0));

    assign mem_busy = (state != IDLE);

    // Storage has no reset; a reset asserted at the commit edge kills the write.
    always_ff @(posedge clk) begin
        if (commit && in_range && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_mask[i]) begin
                    mem[idx][8*i +: 8] <= sel_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            addr_q         <= '0;
            data_q         <= '0;
            mask_q         <= '0;
            mem_resp_valid <= 1'b0;
            mem_excpt      <= 1'b0;
            mem_data_out   <= 32'h0;
        end else begin
            mem_resp_valid <= 1'b0;
            mem_excpt      <= 1'b0;
            if (commit) begin
                state          <= RESP;
                mem_resp_valid <= 1'b1;
                mem_excpt      <= !in_range;
                mem_data_out   <= (in_range && sel_mask == 4'b0000)
                                  ? mem[idx] : 32'h0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (mem_req_valid) begin
                            addr_q <= mem_addr;
                            data_q <= mem_data_in;
                            mask_q <= mem_write_en;
                            cnt    <= CNT_INIT;
                            state  <= WAIT;
                        end
                    end
                    WAIT:    cnt   <= cnt - 4'd1;
                    RESP:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed self-checking bench for mips_dmem_responder.
// Builds with LATENCY 2 (main), 4 (reset abort), 1 and 15 (back-to-back).
module tb_mips_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst4 = 1'b1;
    logic        valid = 1'b0;
    logic [29:0] addr = '0;
    logic [31:0] din = '0;
    logic [3:0]  we = '0;
    logic        vc = 1'b0;

    logic        busy_a, rv_a, ex_a;
    logic [31:0] do_a;
    logic        busy_b, rv_b, ex_b;
    logic [31:0] do_b;
    logic        busy_c, rv_c, ex_c;
    logic [31:0] do_c;
    logic        busy_d, rv_d, ex_d;
    logic [31:0] do_d;

    int checks = 0;
    int errors = 0;

    int          cur = 0;
    logic        o_busy, o_rv, o_ex;
    logic [31:0] o_do;

    always #5 clk = ~clk;

    mips_dmem_responder #(.LATENCY(2)) dut (
        .clk(clk), .rst(rst), .mem_req_valid(valid), .mem_addr(addr),
        .mem_data_in(din), .mem_write_en(we), .mem_busy(busy_a),
        .mem_resp_valid(rv_a), .mem_data_out(do_a), .mem_excpt(ex_a));

    mips_dmem_responder #(.LATENCY(4)) d4 (
        .clk(clk), .rst(rst4), .mem_req_valid(valid), .mem_addr(addr),
        .mem_data_in(din), .mem_write_en(we), .mem_busy(busy_b),
        .mem_resp_valid(rv_b), .mem_data_out(do_b), .mem_excpt(ex_b));

    mips_dmem_responder #(.LATENCY(1)) d1 (
        .clk(clk), .rst(rst), .mem_req_valid(vc),
        .mem_addr(30'h04000000), .mem_data_in(32'h0),
        .mem_write_en(4'b0000), .mem_busy(busy_c),
        .mem_resp_valid(rv_c), .mem_data_out(do_c), .mem_excpt(ex_c));

    mips_dmem_responder #(.LATENCY(15)) d15 (
        .clk(clk), .rst(rst), .mem_req_valid(vc),
        .mem_addr(30'h04000000), .mem_data_in(32'h0),
        .mem_write_en(4'b0000), .mem_busy(busy_d),
        .mem_resp_valid(rv_d), .mem_data_out(do_d), .mem_excpt(ex_d));

    always_comb begin
        o_busy = busy_a;
        o_rv   = rv_a;
        o_ex   = ex_a;
        o_do   = do_a;
        if (cur == 1) begin
            o_busy = busy_b;
            o_rv   = rv_b;
            o_ex   = ex_b;
            o_do   = do_b;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input int sel, input logic [29:0] a,
                          input logic [31:0] d, input logic [3:0] m,
                          input int lat, input logic exp_ex,
                          input logic [31:0] exp_do, input string tag);
        int n;
        cur = sel;
        @(negedge clk);
        valid = 1'b1;
        addr  = a;
        din   = d;
        we    = m;
        @(negedge clk);
        valid = 1'b0;
        we    = 4'b0000;
        n     = 1;
        chk({tag, " busy1"}, 32'(o_busy), 32'd1);
        while (!o_rv && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, n, lat);
        chk({tag, " resp"}, 32'(o_rv), 32'd1);
        chk({tag, " busy_resp"}, 32'(o_busy), 32'd1);
        chk({tag, " excpt"}, 32'(o_ex), 32'(exp_ex));
        chk({tag, " data"}, o_do, exp_do);
        @(negedge clk);
        chk({tag, " resp_end"}, 32'(o_rv), 32'd0);
        chk({tag, " idle"}, 32'(o_busy), 32'd0);
        chk({tag, " excpt_end"}, 32'(o_ex), 32'd0);
    endtask

    initial begin
        int seen;
        int last1, last15, n1, n15;

        #3;
        chk("rst busy", 32'(busy_a), 32'd0);
        chk("rst resp", 32'(rv_a), 32'd0);
        chk("rst excpt", 32'(ex_a), 32'd0);
        chk("rst data", do_a, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        do_req(0, 30'h04000000, 32'hDEADBEEF, 4'b1111, 2, 1'b0, 32'h0,
               "st_full");
        do_req(0, 30'h04000000, 32'h0, 4'b0000, 2, 1'b0, 32'hDEADBEEF,
               "ld_full");
        repeat (3) @(negedge clk);
        chk("hold data", do_a, 32'hDEADBEEF);

        dut.mem[1] = 32'h11223344;
        do_req(0, 30'h04000001, 32'hAABBCCDD, 4'b0101, 2, 1'b0, 32'h0,
               "st_mask");
        do_req(0, 30'h04000001, 32'h0, 4'b0000, 2, 1'b0, 32'h11BB33DD,
               "ld_mask");

        dut.mem[1023] = 32'hCAFEF00D;
        do_req(0, 30'h03FFFFFF, 32'h0, 4'b0000, 2, 1'b1, 32'h0, "ld_low");
        do_req(0, 30'h04000400, 32'h0, 4'b0000, 2, 1'b1, 32'h0, "ld_high");
        do_req(0, 30'h03FFFFFF, 32'hFFFFFFFF, 4'b1111, 2, 1'b1, 32'h0,
               "st_low");
        do_req(0, 30'h04000400, 32'hFFFFFFFF, 4'b1111, 2, 1'b1, 32'h0,
               "st_high");
        do_req(0, 30'h040003FF, 32'h0, 4'b0000, 2, 1'b0, 32'hCAFEF00D,
               "ld_last");
        do_req(0, 30'h04000000, 32'h0, 4'b0000, 2, 1'b0, 32'hDEADBEEF,
               "ld_first");

        // Reset abort on the LATENCY=4 instance.
        @(negedge clk);
        rst4 = 1'b0;
        d4.mem[5] = 32'h0BADC0DE;
        cur = 1;
        @(negedge clk);
        valid = 1'b1;
        addr  = 30'h04000005;
        din   = 32'h12345678;
        we    = 4'b1111;
        @(negedge clk);
        valid = 1'b0;
        we    = 4'b0000;
        chk("abort busy", 32'(busy_b), 32'd1);
        #2;
        rst4 = 1'b1;
        #1;
        chk("abort busy0", 32'(busy_b), 32'd0);
        chk("abort resp0", 32'(rv_b), 32'd0);
        chk("abort excpt0", 32'(ex_b), 32'd0);
        chk("abort data0", do_b, 32'h0);
        @(negedge clk);
        rst4 = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rv_b) seen = 1;
        end
        chk("abort no_resp", seen, 0);
        do_req(1, 30'h04000005, 32'h0, 4'b0000, 4, 1'b0, 32'h0BADC0DE,
               "abort_ld");

        // Back-to-back requests on LATENCY=1 and LATENCY=15.
        @(negedge clk);
        vc = 1'b1;
        last1  = -1;
        last15 = -1;
        n1     = 0;
        n15    = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (rv_c) begin
                if (last1 < 0) chk("l1 first", k, 1);
                else chk("l1 gap", k - last1, 2);
                last1 = k;
                n1++;
            end
            if (rv_d) begin
                if (last15 < 0) chk("l15 first", k, 15);
                else chk("l15 gap", k - last15, 16);
                last15 = k;
                n15++;
            end
        end
        vc = 1'b0;
        chk("l1 count", n1, 32);
        chk("l15 count", n15, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
